// File: rtl/mem_buffer_filler.sv
// Purpose: line-granular DMA writer that fills memory with word i = seed + i*stride,
//          one 128-bit line write outstanding at a time on the memory request/response path.
// Latency: request valid the cycle after start; 2 cycles per line with immediate ready and
//          a 1-cycle response; count==0 or misaligned base finishes the cycle after start.
// Backpressure: mem_req_valid is held with line/data/mask stable until mem_req_ready.
// Ports: clock/reset (sync, active-high); start/base_addr/count/seed/stride command;
//        busy/done/error status; mem_req_* line write request; mem_rsp_valid completion;
//        words_written progress counter.
module mem_buffer_filler #(
    parameter int ADDR_WIDTH  = 32,
    parameter int WORD_WIDTH  = 32,
    parameter int LINE_WORDS  = 4,
    parameter int COUNT_WIDTH = 20
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             start,
    input  logic [ADDR_WIDTH-1:0]            base_addr,
    input  logic [COUNT_WIDTH-1:0]           count,
    input  logic [WORD_WIDTH-1:0]            seed,
    input  logic [WORD_WIDTH-1:0]            stride,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic                             mem_req_valid,
    input  logic                             mem_req_ready,
    output logic [ADDR_WIDTH-5:0]            mem_req_line,
    output logic [LINE_WORDS*WORD_WIDTH-1:0] mem_req_data,
    output logic [LINE_WORDS-1:0]            mem_req_mask,
    input  logic                             mem_rsp_valid,
    output logic [COUNT_WIDTH-1:0]           words_written
);

    localparam int LINE_IDX_W = ADDR_WIDTH - 4;
    localparam int DATA_W     = LINE_WORDS * WORD_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT_RSP,
        S_FINISH
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;

    logic [COUNT_WIDTH-1:0]  r_rem;         // words still to be acknowledged
    logic [COUNT_WIDTH-1:0]  r_words;
    logic                    r_err;
    logic [WORD_WIDTH-1:0]   r_stride;
    logic [WORD_WIDTH-1:0]   r_next_base;   // value of word 0 of the next line
    logic [LINE_IDX_W-1:0]   r_line;
    logic [DATA_W-1:0]       r_data;
    logic [LINE_WORDS-1:0]   r_mask;

    logic                    w_start_ok;
    logic [COUNT_WIDTH-1:0]  w_line_words;
    logic [COUNT_WIDTH-1:0]  w_rem_next;
    logic [WORD_WIDTH-1:0]   w_chain [LINE_WORDS+1];
    logic [LINE_WORDS-1:0]   w_mask_next;
    logic [DATA_W-1:0]       w_data_next;

    assign w_start_ok   = start && (count != '0) && (base_addr[3:0] == 4'h0);
    // Words carried by the line currently in flight: full line or the tail.
    assign w_line_words = (r_rem >= COUNT_WIDTH'(LINE_WORDS)) ? COUNT_WIDTH'(LINE_WORDS) : r_rem;
    assign w_rem_next   = r_rem - w_line_words;

    // Word values of the line about to be loaded, by repeated addition. The same
    // adder chain serves the first line (from seed/stride inputs while idle) and
    // every following line (from the latched next-line base and stride).
    always_comb begin
        logic [WORD_WIDTH-1:0]  v_acc;
        logic [WORD_WIDTH-1:0]  v_step;
        logic [COUNT_WIDTH-1:0] v_rem;
        v_acc  = (r_state == S_IDLE) ? seed   : r_next_base;
        v_step = (r_state == S_IDLE) ? stride : r_stride;
        v_rem  = (r_state == S_IDLE) ? count  : w_rem_next;
        for (int k = 0; k <= LINE_WORDS; k++) begin
            w_chain[k] = v_acc;
            v_acc      = v_acc + v_step;
        end
        w_mask_next = '0;
        w_data_next = '0;
        for (int k = 0; k < LINE_WORDS; k++) begin
            w_mask_next[k] = (COUNT_WIDTH'(k) < v_rem);
            if (w_mask_next[k]) begin
                w_data_next[k*WORD_WIDTH +: WORD_WIDTH] = w_chain[k];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state  = r_state;
        busy          = 1'b0;
        done          = 1'b0;
        error         = 1'b0;
        mem_req_valid = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = w_start_ok ? S_REQ : S_FINISH;
                end
            end
            S_REQ: begin
                busy          = 1'b1;
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    w_next_state = S_WAIT_RSP;
                end
            end
            S_WAIT_RSP: begin
                busy = 1'b1;
                if (mem_rsp_valid) begin
                    w_next_state = (w_rem_next == '0) ? S_FINISH : S_REQ;
                end
            end
            S_FINISH: begin
                done         = 1'b1;
                error        = r_err;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rem       <= '0;
            r_words     <= '0;
            r_err       <= 1'b0;
            r_stride    <= '0;
            r_next_base <= '0;
            r_line      <= '0;
            r_data      <= '0;
            r_mask      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rem    <= count;
                        r_words  <= '0;
                        r_err    <= (base_addr[3:0] != 4'h0);
                        r_stride <= stride;
                        // Request registers are only loaded when a request will follow.
                        if (w_start_ok) begin
                            r_line      <= base_addr[ADDR_WIDTH-1:4];
                            r_data      <= w_data_next;
                            r_mask      <= w_mask_next;
                            r_next_base <= w_chain[LINE_WORDS];
                        end
                    end
                end
                S_WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        r_words     <= r_words + w_line_words;
                        r_rem       <= w_rem_next;
                        r_line      <= r_line + LINE_IDX_W'(1);  // wraps naturally
                        r_data      <= w_data_next;
                        r_mask      <= w_mask_next;
                        r_next_base <= w_chain[LINE_WORDS];
                    end
                end
                default: ;
            endcase
        end
    end

    assign mem_req_line  = r_line;
    assign mem_req_data  = r_data;
    assign mem_req_mask  = r_mask;
    assign words_written = r_words;

endmodule

// File: tb/tb_mem_buffer_filler.sv
module tb_mem_buffer_filler;

    localparam int AW = 32;
    localparam int WW = 32;
    localparam int LW = 4;
    localparam int CW = 20;
    localparam int DW = LW * WW;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] count;
    logic [WW-1:0] seed;
    logic [WW-1:0] stride;
    logic          busy;
    logic          done;
    logic          error;
    logic          mem_req_valid;
    logic          mem_req_ready;
    logic [AW-5:0] mem_req_line;
    logic [DW-1:0] mem_req_data;
    logic [LW-1:0] mem_req_mask;
    logic          mem_rsp_valid;
    logic [CW-1:0] words_written;

    always #5 clock = ~clock;

    mem_buffer_filler #(
        .ADDR_WIDTH (AW),
        .WORD_WIDTH (WW),
        .LINE_WORDS (LW),
        .COUNT_WIDTH(CW)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .base_addr    (base_addr),
        .count        (count),
        .seed         (seed),
        .stride       (stride),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_req_line (mem_req_line),
        .mem_req_data (mem_req_data),
        .mem_req_mask (mem_req_mask),
        .mem_rsp_valid(mem_rsp_valid),
        .words_written(words_written)
    );

    int checks = 0;
    int errors = 0;

    // Captured accepted requests of the latest command.
    logic [AW-5:0] q_line [$];
    logic [DW-1:0] q_data [$];
    logic [LW-1:0] q_mask [$];

    int            res_lat;
    int            res_bad;
    int            res_acc0;
    logic          res_done;
    logic          res_err;
    logic          res_reset_hit;
    logic [CW-1:0] res_ww;

    typedef struct {
        logic [AW-1:0]  base;
        logic [CW-1:0]  cnt;
        logic [WW-1:0]  seed;
        logic [WW-1:0]  stride;
        int             lat;
        int             nreq;
        logic           err;
        logic [AW-5:0]  first_line;
        logic [AW-5:0]  last_line;
        logic [DW-1:0]  first_data;
        logic [DW-1:0]  last_data;
        logic [LW-1:0]  first_mask;
        logic [LW-1:0]  last_mask;
        logic [63:0]    sum;
        logic [CW-1:0]  ww;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_busy"},  128'(busy), 128'(0));
        chk({tag, "_done"},  128'(done), 128'(0));
        chk({tag, "_error"}, 128'(error), 128'(0));
        chk({tag, "_valid"}, 128'(mem_req_valid), 128'(0));
        chk({tag, "_line"},  128'(mem_req_line), 128'(0));
        chk({tag, "_data"},  128'(mem_req_data), 128'(0));
        chk({tag, "_mask"},  128'(mem_req_mask), 128'(0));
        chk({tag, "_ww"},    128'(words_written), 128'(0));
    endtask

    // mode 0: ready always high, response one cycle after accept
    // mode 1: random ready, random response delay, spurious responses during REQ
    // mode 2: ready low for the first 5 valid cycles of line 0, start pulsed while busy
    // mode 3: like mode 0 but reset is asserted in the response wait of line 3
    task automatic run_cmd(input logic [AW-1:0] b, input logic [CW-1:0] c,
                           input logic [WW-1:0] s, input logic [WW-1:0] st, input int mode);
        bit            pending;
        int            delay;
        int            bp_left;
        logic          held;
        logic          rdy;
        logic [AW-5:0] h_line;
        logic [DW-1:0] h_data;
        logic [LW-1:0] h_mask;
        q_line.delete();
        q_data.delete();
        q_mask.delete();
        res_lat = 0; res_bad = 0; res_acc0 = 0;
        res_done = 1'b0; res_err = 1'b0; res_reset_hit = 1'b0; res_ww = '0;
        pending = 1'b0; delay = 0; held = 1'b0;
        h_line = '0; h_data = '0; h_mask = '0;
        bp_left = (mode == 2) ? 5 : 0;
        @(negedge clock);
        start = 1'b1; base_addr = b; count = c; seed = s; stride = st;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        for (int cyc = 1; cyc <= 2000; cyc++) begin
            @(negedge clock);
            start = 1'b0;
            mem_req_ready = 1'b0;
            mem_rsp_valid = 1'b0;
            if (busy !== !done) res_bad++;
            if (done === 1'b1) begin
                res_done = 1'b1; res_lat = cyc; res_err = error; res_ww = words_written;
                break;
            end
            if (held && (mem_req_valid !== 1'b1 || mem_req_line !== h_line ||
                         mem_req_data !== h_data || mem_req_mask !== h_mask)) res_bad++;
            held = 1'b0;
            if (mem_req_valid === 1'b1) begin
                if (pending) res_bad++;
                rdy = 1'b1;
                if (mode == 1) begin
                    rdy = ($urandom_range(0, 2) != 0);
                    mem_rsp_valid = 1'($urandom_range(0, 1));
                end
                if (mode == 2 && q_line.size() == 0 && bp_left > 0) begin
                    rdy = 1'b0;
                    bp_left--;
                end
                if (mode == 2 && cyc == 3) begin
                    start = 1'b1; base_addr = 32'h0000_7770; count = 20'd3;
                end
                mem_req_ready = rdy;
                if (rdy) begin
                    q_line.push_back(mem_req_line);
                    q_data.push_back(mem_req_data);
                    q_mask.push_back(mem_req_mask);
                    if (q_line.size() == 1) res_acc0 = cyc;
                    pending = 1'b1;
                    delay = (mode == 1) ? $urandom_range(0, 3) : 0;
                end else begin
                    held = 1'b1;
                    h_line = mem_req_line; h_data = mem_req_data; h_mask = mem_req_mask;
                end
            end else if (pending) begin
                if (mode == 3 && q_line.size() == 4) begin
                    reset = 1'b1;
                    mem_rsp_valid = 1'b1;
                    res_reset_hit = 1'b1;
                    break;
                end
                if (delay == 0) begin
                    mem_rsp_valid = 1'b1;
                    pending = 1'b0;
                end else begin
                    delay--;
                end
            end
        end
    endtask

    // Reference: line j, word k holds seed + (4j+k)*stride for every word index below count.
    task automatic verify_model(input logic [AW-1:0] b, input logic [CW-1:0] c,
                                input logic [WW-1:0] s, input logic [WW-1:0] st, input int mode);
        int            n;
        int            idx;
        logic [AW-5:0] el;
        logic [DW-1:0] ed;
        logic [LW-1:0] em;
        n = (c != '0 && b[3:0] == 4'h0) ? (int'(c) + LW - 1) / LW : 0;
        chk("done_seen", 128'(res_done), 128'(1));
        chk("nreq", 128'(q_line.size()), 128'(n));
        chk("error", 128'(res_err), 128'(b[3:0] != 4'h0));
        chk("words_written", 128'(res_ww), (n != 0) ? 128'(c) : 128'(0));
        chk("protocol", 128'(res_bad), 128'(0));
        if (mode == 0) chk("latency", 128'(res_lat), (n == 0) ? 128'(1) : 128'(1 + 2 * n));
        if (mode == 2) begin
            chk("latency_bp", 128'(res_lat), 128'(6 + 2 * n));
            chk("accept_cycle", 128'(res_acc0), 128'(6));
        end
        for (int j = 0; j < q_line.size() && j < n; j++) begin
            el = b[AW-1:4] + (AW-4)'(j);
            ed = '0;
            em = '0;
            for (int k = 0; k < LW; k++) begin
                idx = LW * j + k;
                if (idx < int'(c)) begin
                    ed[k*WW +: WW] = s + st * WW'(idx);
                    em[k] = 1'b1;
                end
            end
            chk($sformatf("line%0d", j), 128'(q_line[j]), 128'(el));
            chk($sformatf("data%0d", j), 128'(q_data[j]), 128'(ed));
            chk($sformatf("mask%0d", j), 128'(q_mask[j]), 128'(em));
        end
    endtask

    initial begin
        logic [63:0]   sum;
        logic [AW-1:0] rb;
        logic [CW-1:0] rc;
        logic [WW-1:0] rs;
        logic [WW-1:0] rst;

        vecs[0] = '{32'h0000_1800, 20'd128, 32'd0, 32'd1, 65, 32, 1'b0, 28'h180, 28'h19F,
                    128'h00000003_00000002_00000001_00000000,
                    128'h0000007F_0000007E_0000007D_0000007C, 4'hF, 4'hF, 64'd8128, 20'd128};
        vecs[1] = '{32'h0000_2000, 20'd6, 32'd10, 32'd5, 5, 2, 1'b0, 28'h200, 28'h201,
                    128'h00000019_00000014_0000000F_0000000A,
                    128'h00000000_00000000_00000023_0000001E, 4'hF, 4'h3, 64'd135, 20'd6};
        vecs[2] = '{32'h0000_0000, 20'd0, 32'd5, 32'd5, 1, 0, 1'b0, '0, '0, '0, '0, '0, '0, '0, 20'd0};
        vecs[3] = '{32'h0000_1804, 20'd4, 32'd1, 32'd1, 1, 0, 1'b1, '0, '0, '0, '0, '0, '0, '0, 20'd0};
        vecs[4] = '{32'h0000_0040, 20'd4, 32'hFFFF_FFFE, 32'd1, 3, 1, 1'b0, 28'h4, 28'h4,
                    128'h00000001_00000000_FFFFFFFF_FFFFFFFE,
                    128'h00000001_00000000_FFFFFFFF_FFFFFFFE, 4'hF, 4'hF, 64'h1_FFFF_FFFE, 20'd4};
        vecs[5] = '{32'hFFFF_FFE0, 20'd12, 32'd0, 32'd2, 7, 3, 1'b0, 28'hFFFFFFE, 28'h0,
                    128'h00000006_00000004_00000002_00000000,
                    128'h00000016_00000014_00000012_00000010, 4'hF, 4'hF, 64'd132, 20'd12};
        vecs[6] = '{32'h0000_1808, 20'd0, 32'd0, 32'd0, 1, 0, 1'b1, '0, '0, '0, '0, '0, '0, '0, 20'd0};

        reset = 1'b1; start = 1'b0; base_addr = '0; count = '0; seed = '0; stride = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
        repeat (3) @(negedge clock);
        check_reset_vals("reset");
        reset = 1'b0;

        for (int v = 0; v < 7; v++) begin
            run_cmd(vecs[v].base, vecs[v].cnt, vecs[v].seed, vecs[v].stride, 0);
            verify_model(vecs[v].base, vecs[v].cnt, vecs[v].seed, vecs[v].stride, 0);
            chk($sformatf("v%0d_latency", v), 128'(res_lat), 128'(vecs[v].lat));
            chk($sformatf("v%0d_nreq", v), 128'(q_line.size()), 128'(vecs[v].nreq));
            chk($sformatf("v%0d_error", v), 128'(res_err), 128'(vecs[v].err));
            chk($sformatf("v%0d_ww", v), 128'(res_ww), 128'(vecs[v].ww));
            if (vecs[v].nreq > 0 && q_line.size() > 0) begin
                sum = '0;
                foreach (q_data[i]) begin
                    for (int k = 0; k < LW; k++) sum = sum + 64'(q_data[i][k*WW +: WW]);
                end
                chk($sformatf("v%0d_first_line", v), 128'(q_line[0]), 128'(vecs[v].first_line));
                chk($sformatf("v%0d_first_data", v), 128'(q_data[0]), 128'(vecs[v].first_data));
                chk($sformatf("v%0d_first_mask", v), 128'(q_mask[0]), 128'(vecs[v].first_mask));
                chk($sformatf("v%0d_last_line", v), 128'(q_line[q_line.size()-1]), 128'(vecs[v].last_line));
                chk($sformatf("v%0d_last_data", v), 128'(q_data[q_data.size()-1]), 128'(vecs[v].last_data));
                chk($sformatf("v%0d_last_mask", v), 128'(q_mask[q_mask.size()-1]), 128'(vecs[v].last_mask));
                chk($sformatf("v%0d_sum", v), 128'(sum), 128'(vecs[v].sum));
            end
        end

        // Backpressure on line 0 plus a start pulse while busy.
        run_cmd(32'h0000_3000, 20'd8, 32'd100, 32'd3, 2);
        verify_model(32'h0000_3000, 20'd8, 32'd100, 32'd3, 2);

        // Reset during the response wait of line 3, late response, then a fresh command.
        run_cmd(32'h0000_4000, 20'd32, 32'd7, 32'd3, 3);
        chk("reset_hit", 128'(res_reset_hit), 128'(1));
        chk("reset_nreq", 128'(q_line.size()), 128'(4));
        @(negedge clock);
        check_reset_vals("midreset");
        reset = 1'b0;
        mem_rsp_valid = 1'b1;
        @(negedge clock);
        mem_rsp_valid = 1'b0;
        chk("post_reset_idle", 128'({busy, done, error, mem_req_valid}), 128'(0));
        run_cmd(32'h0000_4000, 20'd32, 32'd7, 32'd3, 0);
        verify_model(32'h0000_4000, 20'd32, 32'd7, 32'd3, 0);

        // Randomized commands against the reference.
        for (int r = 0; r < 25; r++) begin
            rb = $urandom() & 32'hFFFF_FFF0;
            if ($urandom_range(0, 7) == 0) rb[3:0] = 4'($urandom_range(1, 15));
            if ($urandom_range(0, 5) == 0) rb[31:8] = 24'hFFFFFF;
            rc  = CW'($urandom_range(0, 40));
            rs  = $urandom();
            rst = $urandom();
            run_cmd(rb, rc, rs, rst, 1);
            verify_model(rb, rc, rs, rst, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_buffer_filler.md
# mem_buffer_filler

Line-granular DMA writer that fills a word buffer in memory with an arithmetic sequence (word i = seed + i·stride) ahead of CPU programs that read and reduce that buffer. It sits beside the CPU core as a second initiator on the memory core request/response path, with line writes issued one at a time under a valid/ready handshake. It replaces test-bench back-door preloading of memory lines with a real bus-visible writer.

## Interface

Parameters:
- ADDR_WIDTH, 32, byte-address width; line index width is ADDR_WIDTH-4
- WORD_WIDTH, 32, data word width
- LINE_WORDS, 4, words per memory line (line = 128 bits, 16 bytes)
- COUNT_WIDTH, 20, width of the word-count operand

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle command strobe, sampled only in IDLE
- base_addr  in  ADDR_WIDTH  byte address of word 0, must be 16-byte aligned
- count  in  COUNT_WIDTH  number of words to write
- seed  in  WORD_WIDTH  value of word 0
- stride  in  WORD_WIDTH  increment between consecutive words
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle completion pulse
- error  out  1  one-cycle pulse coincident with done when base_addr is misaligned
- mem_req_valid  out  1  line write request valid
- mem_req_ready  in  1  memory accepts the request this cycle
- mem_req_line  out  ADDR_WIDTH-4  line index (byte address >> 4)
- mem_req_data  out  LINE_WORDS·WORD_WIDTH  line data, word k at bits [WORD_WIDTH·k +: WORD_WIDTH]
- mem_req_mask  out  LINE_WORDS  per-word write enable
- mem_rsp_valid  in  1  write completion for the outstanding request
- words_written  out  COUNT_WIDTH  words acknowledged so far in the current command

## Operation

- States: IDLE, REQ, WAIT_RSP, FINISH.
- IDLE: start=1 latches base_addr, count, seed, stride; clears words_written. If count==0 or base_addr[3:0]!=0, go to FINISH (error set for misalignment only; count==0 with misalignment also flags error). Otherwise go to REQ. start in any other state is ignored.
- REQ: mem_req_valid=1; line, data, mask are registered and stay stable until valid&ready. On handshake, go to WAIT_RSP.
- WAIT_RSP: waits for mem_rsp_valid. On it, words_written += words in the line, next value and line index advance. If words_written reaches count, go to FINISH; else REQ.
- FINISH: done=1 (error=1 if flagged) for one cycle, busy=0, back to IDLE.
- Line data: word k of line j = seed + (4j+k)·stride, modulo 2^WORD_WIDTH. Next line value computed by repeated addition, no multiplier.
- Mask: 4'hF for full lines; final partial line enables the low (count mod 4) words, with disabled word data driven 0.
- Line index wraps modulo 2^(ADDR_WIDTH-4).
- One request outstanding at most; mem_rsp_valid outside WAIT_RSP is ignored.

## Timing

- Reset values: busy=0, done=0, error=0, mem_req_valid=0, mem_req_line=0, mem_req_data=0, mem_req_mask=0, words_written=0; state IDLE.
- start at cycle t -> busy=1 and mem_req_valid=1 at t+1.
- With mem_req_ready held high and mem_rsp_valid one cycle after accept: 2 cycles per line; N lines complete with done at t+1+2N.
- count==0 or misaligned: done (and error) at t+1, no request issued, busy stays 0.
- Backpressure: valid held, line/data/mask unchanged while ready=0.
- Reset mid-operation: next cycle all outputs at reset values, outstanding response discarded, no done pulse.

## Test plan

- base 0x1800, count 128, seed 0, stride 1, ready=1, 1-cycle response -> 32 requests on lines 0x180..0x19F, first data {3,2,1,0}, mask 4'hF each, done at cycle 65 after start, word sum 8128.
- base 0x2000, count 6, seed 10, stride 5 -> line 0x200 data {25,20,15,10} mask 4'hF, line 0x201 data {0,0,35,30} mask 4'b0011, words_written=6 at done.
- count 0 -> done one cycle after start, error=0, mem_req_valid never asserted; base 0x1804 count 4 -> done+error one cycle after start, no request.
- ready held low 5 cycles on line 0 -> valid stays 1, line/data/mask constant, accept on cycle 6; start pulsed while busy -> ignored.
- seed 0xFFFFFFFE, stride 1, count 4 -> data {1,0,0xFFFFFFFF,0xFFFFFFFE}.
- reset asserted during WAIT_RSP of line 3 -> outputs at reset values next cycle, no done; fresh start then completes normally.
